commit_stage: RTL and testbench

- Final pipeline stage of the dual-issue core. Sits directly downstream of the memory stage and consumes its two commit-request slots.
- Registers each bundle once, then drives the two register-file write ports.
- Resolves same-cycle write-after-write hazards between slots, suppresses $0 writes, exports bypass data and keeps a retired-instruction counter.
- Slot 0 is always program-order older than slot 1.

---
 rtl/commit_stage.sv | 89 ++++++++
 tb/tb_commit_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/commit_stage.sv
// Final stage of the dual-issue core: registers one two-slot commit bundle, drives both
// register-file write ports, resolves same-bundle WAW, exports bypass data, counts retirements.
module commit_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          in_valid,
    input  logic [2*DATA_W-1:0] in_result,
    input  logic [1:0]          in_write_reg_need,
    input  logic [2*ADDR_W-1:0] in_write_reg_addr,
    output logic                in_ready,
    input  logic                wb_stall,
    output logic [1:0]          rf_we,
    output logic [2*ADDR_W-1:0] rf_waddr,
    output logic [2*DATA_W-1:0] rf_wdata,
    output logic [1:0]          fwd_valid,
    output logic [2*ADDR_W-1:0] fwd_addr,
    output logic [2*DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]    retired_cnt
);

    logic [1:0]          valid_q;
    logic [1:0]          need_q;
    logic [2*ADDR_W-1:0] addr_q;
    logic [2*DATA_W-1:0] result_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   addr1;
    logic [1:0]          qualify;
    logic                waw;
    logic [CNT_W-1:0]    retire_inc;

    // Stalling freezes the whole bundle; reset forces ready so upstream is never blocked by it.
    assign in_ready = !wb_stall || !resetn;

    // NOTE: the data/address fields are reset too, because rf_waddr/rf_wdata/fwd_* are
    // observable outputs that must read 0 during reset, not just "don't care".
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            need_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
        end else if (!wb_stall) begin
            valid_q  <= in_valid;
            need_q   <= in_write_reg_need;
            addr_q   <= in_write_reg_addr;
            result_q <= in_result;
        end
    end

    assign addr0 = addr_q[0 +: ADDR_W];
    assign addr1 = addr_q[ADDR_W +: ADDR_W];

    // A slot qualifies for a write only if it is valid, wants a write and does not target $0.
    always_comb begin
        qualify    = '0;
        qualify[0] = valid_q[0] & need_q[0] & (addr0 != '0);
        qualify[1] = valid_q[1] & need_q[1] & (addr1 != '0);
        waw        = qualify[0] & qualify[1] & (addr0 == addr1);
    end

    // Slot 1 is younger, so on a same-register collision only its value may become visible.
    assign fwd_valid = {qualify[1], qualify[0] & ~waw};
    assign rf_we     = wb_stall ? 2'b00 : fwd_valid;

    assign rf_waddr  = addr_q;
    assign rf_wdata  = result_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = result_q;

    assign retire_inc = CNT_W'(valid_q[0]) + CNT_W'(valid_q[1]);

    // Every valid slot retires, including $0 and no-write slots; the counter wraps freely.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (!wb_stall) begin
            cnt_q <= cnt_q + retire_inc;
        end
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_commit_stage.sv
// Randomized scoreboard bench for commit_stage; a second instance with a 3-bit counter
// exercises counter wrap-around under the same stimulus.
module tb_commit_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    in_valid = '0;
    logic [2*DW-1:0] in_result = '0;
    logic [1:0]    in_need = '0;
    logic [2*AW-1:0] in_addr = '0;
    logic          wb_stall = 1'b0;

    logic          in_ready, in_ready_s;
    logic [1:0]    rf_we, rf_we_s, fwd_valid, fwd_valid_s;
    logic [2*AW-1:0] rf_waddr, rf_waddr_s, fwd_addr, fwd_addr_s;
    logic [2*DW-1:0] rf_wdata, rf_wdata_s, fwd_data, fwd_data_s;
    logic [31:0]   retired_cnt;
    logic [2:0]    retired_cnt_s;

    commit_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_result(in_result),
        .in_write_reg_need(in_need), .in_write_reg_addr(in_addr), .in_ready(in_ready),
        .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retired_cnt(retired_cnt)
    );

    commit_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(3)) dut_small (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_result(in_result),
        .in_write_reg_need(in_need), .in_write_reg_addr(in_addr), .in_ready(in_ready_s),
        .wb_stall(wb_stall), .rf_we(rf_we_s), .rf_waddr(rf_waddr_s), .rf_wdata(rf_wdata_s),
        .fwd_valid(fwd_valid_s), .fwd_addr(fwd_addr_s), .fwd_data(fwd_data_s),
        .retired_cnt(retired_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        bit         need;
        bit [4:0]   a;
        bit [31:0]  d;
    } slot_t;

    typedef struct {
        bit         rdy;
        bit [1:0]   we;
        bit [1:0]   fv;
        bit [9:0]   addr;
        bit [63:0]  data;
        bit [31:0]  cnt;
        bit [2:0]   cnt_s;
    } exp_t;

    slot_t   held [2];
    longint  retired = 0;
    exp_t    exp_q [$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: what the stage shows this cycle, then what the next edge does to it.
    task automatic cycle(input bit rn, input bit stall, input bit [1:0] v, input bit [1:0] need,
                         input bit [4:0] a0, input bit [4:0] a1,
                         input bit [31:0] d0, input bit [31:0] d1);
        exp_t e;
        bit   w0, w1;
        @(posedge clk);
        #1;
        resetn    = rn;
        wb_stall  = stall;
        in_valid  = v;
        in_need   = need;
        in_addr   = {a1, a0};
        in_result = {d1, d0};
        if (!rn) begin
            held[0] = '{default: 0};
            held[1] = '{default: 0};
            retired = 0;
        end
        w0 = held[0].v && held[0].need && held[0].a != 0;
        w1 = held[1].v && held[1].need && held[1].a != 0;
        if (w0 && w1 && held[0].a == held[1].a) w0 = 0;
        e.rdy   = !rn || !stall;
        e.fv    = {w1, w0};
        e.we    = stall ? 2'b00 : {w1, w0};
        e.addr  = {held[1].a, held[0].a};
        e.data  = {held[1].d, held[0].d};
        e.cnt   = 32'(retired);
        e.cnt_s = 3'(retired);
        exp_q.push_back(e);
        if (rn && !stall) begin
            retired += int'(held[0].v) + int'(held[1].v);
            held[0] = '{v: v[0], need: need[0], a: a0, d: d0};
            held[1] = '{v: v[1], need: need[1], a: a1, d: d1};
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("in_ready",    64'(in_ready),      64'(e.rdy));
            check("rf_we",       64'(rf_we),         64'(e.we));
            check("rf_waddr",    64'(rf_waddr),      64'(e.addr));
            check("rf_wdata",    rf_wdata,           e.data);
            check("fwd_valid",   64'(fwd_valid),     64'(e.fv));
            check("fwd_addr",    64'(fwd_addr),      64'(e.addr));
            check("fwd_data",    fwd_data,           e.data);
            check("retired_cnt", 64'(retired_cnt),   64'(e.cnt));
            check("cnt_wrap",    64'(retired_cnt_s), 64'(e.cnt_s));
            check("rf_we_small", 64'(rf_we_s),       64'(e.we));
        end
    end

    function automatic bit [4:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 5'd0;
            1:       return 5'd7;
            2:       return 5'd1;
            3:       return 5'd2;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        held[0] = '{default: 0};
        held[1] = '{default: 0};

        // Power-on reset, then a bundle held while reset hits mid-stream.
        cycle(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(1, 0, 2'b11, 2'b11, 5, 6, 32'h55, 32'h66);
        cycle(1, 1, 2'b11, 2'b11, 5, 6, 32'h55, 32'h66);
        cycle(0, 1, 2'b11, 2'b11, 5, 6, 32'h55, 32'h66);
        cycle(0, 0, 2'b11, 2'b11, 5, 6, 32'h55, 32'h66);

        // First bundle after reset: r3=0x11, r4=0x22.
        cycle(1, 0, 2'b11, 2'b11, 3, 4, 32'h11, 32'h22);
        // WAW on r7: slot 1 wins.
        cycle(1, 0, 2'b11, 2'b11, 7, 7, 32'hAAAA, 32'hBBBB);
        // $0 write plus a no-write slot: nothing written, both retire.
        cycle(1, 0, 2'b11, 2'b01, 0, 9, 32'h5, 32'h99);
        // Stall hold of r9=0x1234 for three cycles with new input pending, then release.
        cycle(1, 0, 2'b01, 2'b01, 9, 0, 32'h1234, 32'h0);
        cycle(1, 1, 2'b01, 2'b01, 1, 0, 32'h7, 32'h0);
        cycle(1, 1, 2'b01, 2'b01, 1, 0, 32'h7, 32'h0);
        cycle(1, 1, 2'b01, 2'b01, 1, 0, 32'h7, 32'h0);
        cycle(1, 0, 2'b01, 2'b01, 1, 0, 32'h7, 32'h0);
        cycle(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // Random traffic with frequent WAW/$0 hits, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 3),
                  2'($urandom), 2'($urandom), pick_addr(), pick_addr(), $urandom, $urandom);
        end
        cycle(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
